// File: rtl/accel_pkg.sv
// Shared types for the compute-unit clients.
// Provides the operation encoding, vector/matrix operand types and the
// requester FSM state type used by compute_requester.
package accel_pkg;

  localparam int unsigned ELEM_WIDTH   = 8;
  localparam int unsigned VECTOR_WIDTH = 4;
  localparam int unsigned MATRIX_DEPTH = 4;

  typedef enum logic [1:0] {
    COMP_ADD,
    COMP_MUL,
    COMP_DOT,
    COMP_MATVEC
  } computation_type_t;

  typedef logic [VECTOR_WIDTH-1:0][ELEM_WIDTH-1:0] vector_data_t;
  typedef vector_data_t [MATRIX_DEPTH-1:0]         matrix_data_t;

  typedef enum logic [1:0] {
    StIdle,
    StReq,
    StWaitDone,
    StResult
  } req_state_t;

endpackage

// File: rtl/compute_requester.sv
// compute_requester: initiator-side client of the shared compute unit.
// Accepts one job from the local unit, requests the shared unit, holds the
// operands stable while it computes, captures the result on done and hands it
// back over a valid/ready handshake. Exactly one job outstanding at a time.
//
// Ports:
//   clk, rst                    clock, synchronous active-high reset
//   job_valid/job_ready         job handshake; job_type/job_a/job_b/job_matrix
//   unit_id                     constant UNIT_ID tag
//   request/ready/done          shared-unit handshake
//   comp_type/vector_a/vector_b/matrix_in  latched operands to the shared unit
//   result                      shared-unit result
//   res_valid/res_ready         result handshake; res_data, res_error
//   busy                        FSM not idle
//   jobs_done                   completed-job counter (wraps)
//
// Optional: define REQ_TIMEOUT_EN to enable a WAIT_DONE watchdog of
// TIMEOUT_CYCLES cycles that returns a zero result with res_error set.
import accel_pkg::*;

module compute_requester #(
  parameter logic [1:0]  UNIT_ID        = 2'd0,
  parameter int unsigned TIMEOUT_CYCLES = 256,
  parameter int unsigned CNT_WIDTH      = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 job_valid,
  output logic                 job_ready,
  input  computation_type_t    job_type,
  input  vector_data_t         job_a,
  input  vector_data_t         job_b,
  input  matrix_data_t         job_matrix,
  output logic [1:0]           unit_id,
  output logic                 request,
  input  logic                 ready,
  input  logic                 done,
  output computation_type_t    comp_type,
  output vector_data_t         vector_a,
  output vector_data_t         vector_b,
  output matrix_data_t         matrix_in,
  input  vector_data_t         result,
  output logic                 res_valid,
  input  logic                 res_ready,
  output vector_data_t         res_data,
  output logic                 res_error,
  output logic                 busy,
  output logic [CNT_WIDTH-1:0] jobs_done
);

  req_state_t             state_q, state_d;
  computation_type_t      type_q, type_d;
  vector_data_t           a_q, a_d;
  vector_data_t           b_q, b_d;
  matrix_data_t           mat_q, mat_d;
  vector_data_t           res_data_q, res_data_d;
  logic [CNT_WIDTH-1:0]   jobs_done_q, jobs_done_d;

`ifdef REQ_TIMEOUT_EN
  localparam int unsigned TmoW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TmoW-1:0] cnt_q, cnt_d;
  logic            res_error_q, res_error_d;
`else
  // The limit has no effect without the watchdog.
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT_CYCLES;
`endif

  always_comb begin
    state_d     = state_q;
    type_d      = type_q;
    a_d         = a_q;
    b_d         = b_q;
    mat_d       = mat_q;
    res_data_d  = res_data_q;
    jobs_done_d = jobs_done_q;
`ifdef REQ_TIMEOUT_EN
    cnt_d       = cnt_q;
    res_error_d = res_error_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (job_valid) begin
          type_d  = job_type;
          a_d     = job_a;
          b_d     = job_b;
          mat_d   = job_matrix;
          state_d = StReq;
        end
      end
      StReq: begin
        // request is high throughout this state, so ready alone is the grant.
        // done is deliberately ignored here.
        if (ready) begin
          state_d = StWaitDone;
`ifdef REQ_TIMEOUT_EN
          cnt_d   = '0;
`endif
        end
      end
      StWaitDone: begin
        // done takes priority over a simultaneous watchdog expiry.
        if (done) begin
          res_data_d  = result;
          jobs_done_d = jobs_done_q + CNT_WIDTH'(1);
          state_d     = StResult;
`ifdef REQ_TIMEOUT_EN
          res_error_d = 1'b0;
        end else if (cnt_q == TmoW'(TIMEOUT_CYCLES - 1)) begin
          res_data_d  = '0;
          res_error_d = 1'b1;
          state_d     = StResult;
        end else begin
          cnt_d = cnt_q + TmoW'(1);
`endif
        end
      end
      StResult: begin
        if (res_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      type_q      <= COMP_ADD;
      a_q         <= '0;
      b_q         <= '0;
      mat_q       <= '0;
      res_data_q  <= '0;
      jobs_done_q <= '0;
`ifdef REQ_TIMEOUT_EN
      cnt_q       <= '0;
      res_error_q <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      type_q      <= type_d;
      a_q         <= a_d;
      b_q         <= b_d;
      mat_q       <= mat_d;
      res_data_q  <= res_data_d;
      jobs_done_q <= jobs_done_d;
`ifdef REQ_TIMEOUT_EN
      cnt_q       <= cnt_d;
      res_error_q <= res_error_d;
`endif
    end
  end

  assign unit_id   = UNIT_ID;
  assign job_ready = (state_q == StIdle);
  assign request   = (state_q == StReq);
  assign res_valid = (state_q == StResult);
  assign busy      = (state_q != StIdle);
  assign comp_type = type_q;
  assign vector_a  = a_q;
  assign vector_b  = b_q;
  assign matrix_in = mat_q;
  assign res_data  = res_data_q;
  assign jobs_done = jobs_done_q;
`ifdef REQ_TIMEOUT_EN
  assign res_error = res_error_q;
`else
  assign res_error = 1'b0;
`endif

endmodule
